seq_restoring_divider: RTL and testbench

//  Iterative unsigned restoring divider. It is the inverse operator to the Wallace tree multiplier in the arithmetic datapath.

---
 rtl/seq_restoring_divider.sv | 100 ++++++++++
 tb/tb_seq_restoring_divider.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, valid/ready on both sides.
// Divide-by-zero resolves immediately with quotient=all ones and remainder=dividend.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtraction is one bit wider than the operands, so its MSB is the borrow.
  always_comb begin
    trial    = {rem, q[WIDTH-1]};
    diff     = trial - {1'b0, dvsr};
    rem_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], ~diff[WIDTH]};
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem         <= '0;
      q           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              rem   <= '0;
              q     <= dividend;
              dvsr  <= divisor;
              cnt   <= CNT_W'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus random divisions
// compared against plain '/' and '%' arithmetic.
module tb_seq_restoring_divider;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction; hold = cycles of out_ready=0 while the result is presented.
  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    logic [WIDTH-1:0] exp_q, exp_r;
    int n;
    exp_q = (b == 0) ? '1 : a / b;
    exp_r = (b == 0) ? a : a % b;
    chk("ready_before", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    // Count edges after the accept edge; a zero divisor resolves on the accept edge itself.
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), (b == 0) ? 64'd0 : 64'(WIDTH));
    chk("quotient", {32'd0, quotient}, {32'd0, exp_q});
    chk("remainder", {32'd0, remainder}, {32'd0, exp_r});
    chk("dbz", {63'd0, div_by_zero}, {63'd0, (b == 0)});
    chk("ready_busy", {63'd0, in_ready}, 64'd0);
    if (b != 0) begin
      chk("invariant", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
      chk("rem_lt_div", {63'd0, (remainder < b)}, 64'd1);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_q", {32'd0, quotient}, {32'd0, exp_q});
      chk("hold_r", {32'd0, remainder}, {32'd0, exp_r});
      chk("hold_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", {63'd0, out_valid}, 64'd0);
    chk("release_ready", {63'd0, in_ready}, 64'd1);
    chk("idle_q_kept", {32'd0, quotient}, {32'd0, exp_q});
    $display("div 0x%08h / 0x%08h -> q=0x%08h r=0x%08h dbz=%0d lat=%0d", a, b, quotient,
             remainder, div_by_zero, n);
  endtask

  initial begin
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] ra, rb;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_q", {32'd0, quotient}, 64'd0);
    chk("rst_r", {32'd0, remainder}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_div(32'd100, 32'd7, 0);
    run_div(32'hFFFFFFFF, 32'd1, 0);
    run_div(32'd3, 32'd10, 1);
    run_div(32'd5, 32'd0, 0);
    run_div(32'd9, 32'd3, 0);
    prod = 32'h80100282 * 32'h60;
    run_div(prod, 32'h60, 0);
    run_div(32'hAAAAAAAA, 32'h55555555, 0);
    run_div(32'd12345, 32'd678, 5);

    // Abort a division mid-flight with reset; previous result must be wiped.
    in_valid = 1'b1;
    dividend = 32'd77777;
    divisor  = 32'd13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_q", {32'd0, quotient}, 64'd0);
    chk("abort_r", {32'd0, remainder}, 64'd0);
    chk("abort_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // No stale result may appear after the abort.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("abort_no_result", 64'(n), 64'd0);
    run_div(32'd1000, 32'd10, 0);

    for (int k = 0; k < 25; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(ra, rb, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
